// File: rtl/wb_rotenc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rotenc_pkg
// Brief    : Register offsets, EVENT bit indices and input ordering for wb_rotenc.
// Revision : 1.0 - initial release
// ============================================================================
package rotenc_pkg;

    localparam int NUM_INPUTS = 7;

    // Word offsets, i.e. wb_adr_i[3:2]
    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_POSITION = 2'd1;
    localparam logic [1:0] REG_EVENT    = 2'd2;
    localparam logic [1:0] REG_IRQEN    = 2'd3;

    localparam int EV_CW   = 0;
    localparam int EV_CCW  = 1;
    localparam int EV_CTR  = 2;
    localparam int EV_BTN0 = 3;

    // Conditioned-input vector order matches STATUS[6:0]: btn[3:0], centre, A, B
    localparam int IN_BTN0 = 0;
    localparam int IN_CTR  = 4;
    localparam int IN_A    = 5;
    localparam int IN_B    = 6;

endpackage
`default_nettype wire

// File: rtl/wb_rotenc_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_rotenc_if
// Brief    : Wishbone classic slave-port bundle for the rotary encoder block.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_rotenc_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_rotenc_debounce.sv
`default_nettype none
// ============================================================================
// Module   : rotenc_debounce
// Brief    : 2-FF synchroniser followed by a stable-count debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module rotenc_debounce #(
    parameter int cycles = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int                 c_CNT_W = $clog2(cycles + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(cycles);

    logic               r_meta;
    logic               r_sync;
    logic               r_dout;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;

    assign w_cnt_next = r_cnt + 1'b1;

    // Toggle on the cycle the count would reach the limit, so a change is
    // visible 1 + cycles edges after it lands in the synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            if (r_sync == r_dout) begin
                r_cnt <= '0;
            end else if (w_cnt_next == c_LIMIT) begin
                r_dout <= ~r_dout;
                r_cnt  <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/wb_rotenc.sv
`default_nettype none
// ============================================================================
// Module   : wb_rotenc
// Brief    : Wishbone slave for push buttons and quadrature rotary encoder.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rotenc
    import rotenc_pkg::*;
#(
    parameter int clk_freq        = 50_000_000,
    parameter int debounce_cycles = 50_000      // 1 ms at 50 MHz
) (
    input  logic              clk,
    input  logic              reset,
    wb_rotenc_if.slave        wb,
    output logic              intr,
    input  logic [3:0]        btn,
    input  logic [2:0]        rot
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [NUM_INPUTS-1:0] w_raw;
    logic [NUM_INPUTS-1:0] w_deb;
    logic [NUM_INPUTS-1:0] r_deb_d;
    logic [NUM_INPUTS-1:0] w_rise;

    logic [0:0]  r_state;
    logic [31:0] r_dat;
    logic [15:0] r_pos;
    logic [6:0]  r_event;
    logic [6:0]  r_irqen;

    logic        w_access;
    logic        w_wr;
    logic [1:0]  w_addr;
    logic        w_pos_wr;
    logic        w_irq_wr;
    logic [6:0]  w_w1c;
    logic [6:0]  w_set;
    logic        w_cw;
    logic        w_ccw;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_raw = {rot[1], rot[0], rot[2], btn};

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
        rotenc_debounce #(
            .cycles (debounce_cycles)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (w_raw[gi]),
            .dout  (w_deb[gi])
        );
    end

    assign w_rise = w_deb & ~r_deb_d;
    assign w_cw   = w_rise[IN_A] & ~w_deb[IN_B];
    assign w_ccw  = w_rise[IN_A] &  w_deb[IN_B];

    always_comb begin
        w_set                      = '0;
        w_set[EV_CW]               = w_cw;
        w_set[EV_CCW]              = w_ccw;
        w_set[EV_CTR]              = w_rise[IN_CTR];
        w_set[EV_BTN0 +: 4]        = w_rise[IN_BTN0 +: 4];
    end

    // Bus decode; the ~ack term limits to one access every two cycles
    assign w_access = wb.wb_cyc_i & wb.wb_stb_i & (r_state == ST_IDLE);
    assign w_addr   = wb.wb_adr_i[3:2];
    assign w_wr     = w_access & wb.wb_we_i & wb.wb_sel_i[0];
    assign w_pos_wr = w_wr & wb.wb_sel_i[1] & (w_addr == REG_POSITION);
    assign w_irq_wr = w_wr & (w_addr == REG_IRQEN);
    assign w_w1c    = (w_wr && (w_addr == REG_EVENT)) ? wb.wb_dat_i[6:0] : 7'd0;

    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            REG_STATUS:   w_rdata = {25'd0, w_deb};
            REG_POSITION: w_rdata = {{16{r_pos[15]}}, r_pos};
            REG_EVENT:    w_rdata = {25'd0, r_event};
            REG_IRQEN:    w_rdata = {25'd0, r_irqen};
            default:      w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_dat   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= w_access ? ST_ACK : ST_IDLE;
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            r_dat <= (w_access && !wb.wb_we_i) ? w_rdata : 32'd0;
        end
    end

    // Bus writes beat steps on POSITION; event sets beat W1C on EVENT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb_d <= '0;
            r_pos   <= 16'd0;
            r_event <= 7'd0;
            r_irqen <= 7'd0;
        end else begin
            r_deb_d <= w_deb;
            if (w_pos_wr) begin
                r_pos <= wb.wb_dat_i[15:0];
            end else if (w_cw) begin
                r_pos <= r_pos + 16'd1;
            end else if (w_ccw) begin
                r_pos <= r_pos - 16'd1;
            end
            r_event <= (r_event & ~w_w1c) | w_set;
            if (w_irq_wr) begin
                r_irqen <= wb.wb_dat_i[6:0];
            end
        end
    end

    assign wb.wb_ack_o = (r_state == ST_ACK);
    assign wb.wb_dat_o = r_dat;
    assign intr        = |(r_event & r_irqen);

    assign w_unused = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:16],
                        wb.wb_sel_i[3:2], 1'(clk_freq % 2)};

endmodule
`default_nettype wire

// File: tb/tb_wb_rotenc.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rotenc
// Brief    : Directed self-checking bench for wb_rotenc with debounce_cycles=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rotenc;

    logic       clk;
    logic       reset;
    logic       intr;
    logic [3:0] btn;
    logic [2:0] rot;

    int n_checks;
    int n_errors;

    wb_rotenc_if bus ();

    wb_rotenc #(
        .clk_freq        (50_000_000),
        .debounce_cycles (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus),
        .intr  (intr),
        .btn   (btn),
        .rot   (rot)
    );

    localparam logic [31:0] A_STATUS = 32'h7003_0000;
    localparam logic [31:0] A_POS    = 32'h7003_0004;
    localparam logic [31:0] A_EVENT  = 32'h7003_0008;
    localparam logic [31:0] A_IRQEN  = 32'h7003_000C;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                              input logic [3:0] sel, output logic [31:0] rdat);
        bit got;
        got  = 1'b0;
        rdat = 32'd0;
        @(negedge clk);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = wdat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            if (bus.wb_ack_o) begin
                got  = 1'b1;
                rdat = bus.wb_dat_o;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        bus_access(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        bus_access(1'b0, adr, 32'd0, 4'hF, d);
        check(tag, d, exp);
    endtask

    task automatic set_rot(input logic [2:0] v, input int hold);
        @(posedge clk);
        #1;
        rot = v;
        repeat (hold) @(posedge clk);
    endtask

    task automatic cw_detent();
        set_rot(3'b001, 10);
        set_rot(3'b000, 10);
    endtask

    task automatic ccw_detent();
        set_rot(3'b010, 10);
        set_rot(3'b011, 10);
        set_rot(3'b010, 10);
        set_rot(3'b000, 10);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        btn          = 4'd0;
        rot          = 3'd0;
        bus.wb_adr_i = 32'd0;
        bus.wb_dat_i = 32'd0;
        bus.wb_sel_i = 4'd0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("reset_intr", {31'd0, intr}, 32'd0);
        reset = 1'b0;

        // Build up state, then reset in the middle of a read
        wb_write(A_IRQEN, 32'h7F, 4'hF);
        wb_write(A_POS, 32'h1234, 4'hF);
        @(posedge clk); #1; btn[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1; btn[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_intr", {31'd0, intr}, 32'd1);
        @(negedge clk);
        bus.wb_adr_i = A_POS;
        bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_ack", {31'd0, bus.wb_ack_o}, 32'd1);
        reset = 1'b1;
        #1;
        check("midread_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("midread_dat", bus.wb_dat_o, 32'd0);
        check("midread_intr", {31'd0, intr}, 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        read_check("rst_status", A_STATUS, 32'h0);
        read_check("rst_pos", A_POS, 32'h0);
        read_check("rst_event", A_EVENT, 32'h0);
        read_check("rst_irqen", A_IRQEN, 32'h0);

        // CW / CCW steps
        wb_write(A_IRQEN, 32'h01, 4'hF);
        repeat (3) cw_detent();
        read_check("cw3_pos", A_POS, 32'h0000_0003);
        read_check("cw3_event", A_EVENT, 32'h01);
        check("cw3_intr", {31'd0, intr}, 32'd1);
        wb_write(A_EVENT, 32'h01, 4'hF);
        check("w1c_intr", {31'd0, intr}, 32'd0);
        read_check("w1c_event", A_EVENT, 32'h00);
        ccw_detent();
        read_check("ccw_pos", A_POS, 32'h0000_0002);
        read_check("ccw_event", A_EVENT, 32'h02);
        check("ccw_intr_masked", {31'd0, intr}, 32'd0);

        // Wrap both directions
        wb_write(A_EVENT, 32'h7F, 4'hF);
        wb_write(A_POS, 32'h7FFF, 4'hF);
        cw_detent();
        read_check("wrap_up", A_POS, 32'hFFFF_8000);
        wb_write(A_POS, 32'h0000, 4'hF);
        ccw_detent();
        read_check("wrap_down", A_POS, 32'hFFFF_FFFF);
        wb_write(A_EVENT, 32'h7F, 4'hF);

        // Debounce: 3-cycle glitch rejected, sustained press accepted
        @(posedge clk); #1; btn[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1; btn[2] = 1'b0;
        repeat (10) @(posedge clk);
        read_check("glitch_event", A_EVENT, 32'h00);
        read_check("glitch_status", A_STATUS, 32'h00);
        @(posedge clk); #1; btn[2] = 1'b1;
        repeat (10) @(posedge clk);
        read_check("press_event", A_EVENT, 32'h20);
        read_check("press_status", A_STATUS, 32'h04);
        @(posedge clk); #1; btn[2] = 1'b0;
        repeat (10) @(posedge clk);
        wb_write(A_EVENT, 32'h7F, 4'hF);

        // Centre press: flag set lands on the same edge as W1C of bit 2
        @(posedge clk); #1; rot[2] = 1'b1;
        repeat (6) @(posedge clk);
        wb_write(A_EVENT, 32'h04, 4'hF);
        read_check("coll_event", A_EVENT, 32'h04);
        @(posedge clk); #1; rot[2] = 1'b0;
        repeat (10) @(posedge clk);
        wb_write(A_EVENT, 32'h7F, 4'hF);

        // POSITION write on the same edge as a CW step
        @(posedge clk); #1; rot[0] = 1'b1;
        repeat (6) @(posedge clk);
        wb_write(A_POS, 32'h0010, 4'hF);
        read_check("coll_pos", A_POS, 32'h0000_0010);
        @(posedge clk); #1; rot[0] = 1'b0;
        repeat (10) @(posedge clk);

        // Held strobe: ack alternates
        @(negedge clk);
        bus.wb_adr_i = A_STATUS;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        check("held_ack0", {31'd0, bus.wb_ack_o}, 32'd0);
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("held_ack%0d", i), {31'd0, bus.wb_ack_o}, 32'(i % 2));
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;

        // Byte-select gating and read-only STATUS
        wb_write(A_IRQEN, 32'h55, 4'hF);
        read_check("irqen_set", A_IRQEN, 32'h55);
        wb_write(A_IRQEN, 32'h2A, 4'h0);
        read_check("irqen_sel0", A_IRQEN, 32'h55);
        wb_write(A_STATUS, 32'h7F, 4'hF);
        read_check("status_ro", A_STATUS, 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
